// File: rtl/mult16_seq_pkg.sv
// Shared types and sizing for the bit-serial multiplier sequencer.
// Optional self-check hardware is enabled by defining MULT16_SEQ_SELF_CHECK_EN.
package mult16_seq_pkg;

    localparam int WIDTH        = 16;
    localparam int PWIDTH       = 2 * WIDTH;
    localparam int CNT_W        = 5;
    localparam int CLEAR_CYCLES = 32;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        MUL,
        FLUSH,
        RESP
    } state_t;

endpackage

// File: rtl/mult16_seq_shreg.sv
// Product collector: 2*WIDTH right-shift register, serial bit enters at the MSB,
// so after 2*WIDTH shifts bit k holds the bit sampled in cycle k.
module mult16_seq_shreg
    import mult16_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              serial_in,
    output logic [PWIDTH-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            data <= '0;
        end else if (shift) begin
            data <= {serial_in, data[PWIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequencer for the 16x16 bit-serial carry-save multiplier array.
// Define MULT16_SEQ_SELF_CHECK_EN to add the reference multiplier and sticky chk_err.
module mult16_seq_ctrl
    import mult16_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PWIDTH-1:0] rsp_product,
    output logic [WIDTH-1:0]  mul_a,
    output logic              mul_b_bit,
    input  logic              mul_p_bit,
    output logic              busy
`ifdef MULT16_SEQ_SELF_CHECK_EN
    ,
    output logic              chk_err
`endif
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   b_sh;
    logic               accept;
    logic               shift_en;
    logic               last_step;
    logic [PWIDTH-1:0]  product;

    assign accept    = (state == IDLE) && req_valid;
    assign shift_en  = (state == MUL) || (state == FLUSH);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    mult16_seq_shreg u_shreg (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .shift     (shift_en),
        .serial_in (mul_p_bit),
        .data      (product)
    );

    assign rsp_product = product;

    // NOTE: reset is synchronous, so it lives inside the clocked block and has
    // priority over every state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            b_sh      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            mul_a     <= '0;
            mul_b_bit <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                // The array has no reset; zero inputs flush whatever it powered up with.
                CLEAR: begin
                    if (cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        state     <= MUL;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        mul_a     <= req_a;
                        mul_b_bit <= req_b[0];
                        b_sh      <= req_b >> 1;
                    end
                end
                MUL: begin
                    mul_b_bit <= b_sh[0];
                    b_sh      <= b_sh >> 1;
                    if (last_step) begin
                        state     <= FLUSH;
                        cnt       <= '0;
                        mul_b_bit <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (last_step) begin
                        state     <= RESP;
                        cnt       <= '0;
                        mul_a     <= '0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    mul_a     <= '0;
                    mul_b_bit <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

`ifdef MULT16_SEQ_SELF_CHECK_EN
    logic [PWIDTH-1:0] ref_product;

    // The final shift lands on the RESP-entry edge, so compare against the incoming value.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_product <= '0;
            chk_err     <= 1'b0;
        end else begin
            if (accept) begin
                ref_product <= PWIDTH'(req_a) * PWIDTH'(req_b);
            end
            if ((state == FLUSH) && last_step &&
                ({mul_p_bit, product[PWIDTH-1:1]} != ref_product)) begin
                chk_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench for mult16_seq_ctrl with a behavioural shift-add model of the
// serial multiplier array; MULT16_SEQ_SELF_CHECK_EN also exercises chk_err.
module tb_mult16_seq_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_product;
    logic [15:0] mul_a;
    logic        mul_b_bit;
    logic        mul_p_bit;
    logic        busy;
`ifdef MULT16_SEQ_SELF_CHECK_EN
    logic        chk_err;
`endif

    int checks   = 0;
    int failures = 0;

    mult16_seq_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .mul_a       (mul_a),
        .mul_b_bit   (mul_b_bit),
        .mul_p_bit   (mul_p_bit),
        .busy        (busy)
`ifdef MULT16_SEQ_SELF_CHECK_EN
        ,
        .chk_err     (chk_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Array model: running partial sum; each cycle adds A when the serial bit is set,
    // emits the LSB as the product bit and keeps the rest as carry into the next cycle.
    logic [17:0] arr_acc;
    logic [18:0] arr_sum;
    logic        preload;
    logic [17:0] preload_val;
    logic        p_flip;

    assign arr_sum   = {1'b0, arr_acc} + (mul_b_bit ? {3'b000, mul_a} : 19'd0);
    assign mul_p_bit = arr_sum[0] ^ p_flip;

    always @(posedge clock) begin
        if (preload) arr_acc <= preload_val;
        else         arr_acc <= arr_sum[18:1];
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Called at the negedge where reset has just been released: CLEAR must last 32 cycles.
    task automatic count_clear(input string tag);
        int  c = 0;
        bit  saw_rsp = 1'b0;
        while (!req_ready && c < 100) begin
            if (rsp_valid) saw_rsp = 1'b1;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            c++;
            tick();
        end
        check({tag, "_len"}, 32'(c), 32'd32);
        check({tag, "_no_rsp"}, 32'(saw_rsp), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input int flip_cyc, input logic [31:0] exp);
        int          w = 0;
        int          n;
        int          a_bad = 0;
        logic [31:0] bseq = '0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (n <= 32) begin
                bseq[n-1] = mul_b_bit;
                if (mul_a !== a) a_bad++;
            end
            p_flip = (n == flip_cyc);
            tick();
            n++;
        end
        p_flip = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_b_stream"}, bseq, {16'h0000, b});
        check({tag, "_a_hold"}, 32'(a_bad), 32'd0);
        check({tag, "_product"}, rsp_product, exp);
        check({tag, "_resp_mul_a"}, {16'h0000, mul_a}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_product"}, rsp_product, exp);
            check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        req_valid   = 1'b0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b0;
        p_flip      = 1'b0;
        preload     = 1'b1;
        preload_val = 18'($urandom);
        reset       = 1'b1;

        // Reset for three edges with the array holding random residue.
        repeat (3) @(posedge clock);
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_product", rsp_product, 32'd0);
        check("rst_mul_a", {16'h0000, mul_a}, 32'd0);
        check("rst_mul_b_bit", 32'(mul_b_bit), 32'd0);
`ifdef MULT16_SEQ_SELF_CHECK_EN
        check("rst_chk_err", 32'(chk_err), 32'd0);
`endif
        reset   = 1'b0;
        preload = 1'b0;
        count_clear("clear0");

        // First op proves the drain removed the preloaded residue.
        do_op("op_3x5", 16'h0003, 16'h0005, 0, 0, 32'h0000_000F);
        do_op("op_ffff", 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE_0001);
        do_op("op_8000x2", 16'h8000, 16'h0002, 10, 0, 32'h0001_0000);
        do_op("op_zero", 16'h0000, 16'($urandom), 1, 0, 32'h0000_0000);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op("op_rand", ra, rb, int'($urandom_range(0, 3)), 0, 32'(ra) * 32'(rb));
        end
`ifdef MULT16_SEQ_SELF_CHECK_EN
        check("chk_err_clean", 32'(chk_err), 32'd0);
`endif

        // Abort in MUL cycle 7: no response, full drain, then a clean op.
        req_valid = 1'b1;
        req_a     = 16'hABCD;
        req_b     = 16'hFFFF;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        count_clear("clear1");
        do_op("op_1234x10", 16'h1234, 16'h0010, 2, 0, 32'h0001_2340);

`ifdef MULT16_SEQ_SELF_CHECK_EN
        // Corrupt the product bit sampled in overall cycle 2.
        do_op("op_flip", 16'h00FF, 16'h00FF, 0, 3, (32'h0000_FE01) ^ 32'h0000_0004);
        check("chk_err_set", 32'(chk_err), 32'd1);
        do_op("op_after_flip", 16'h0101, 16'h0003, 0, 0, 32'h0000_0303);
        check("chk_err_sticky", 32'(chk_err), 32'd1);
        reset = 1'b1;
        tick();
        check("chk_err_reset", 32'(chk_err), 32'd0);
        reset = 1'b0;
        count_clear("clear2");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
